// File: rtl/dsp19x2_result_unpacker.sv
// dsp19x2_result_unpacker
// Buffers packed dual-multiplier results {Z1, Z2} in a small FIFO and
// serializes each word into two 19-bit lane results on a valid/ready stream.
// The lane emitted first is selected by LANE_ORDER ("Z1_FIRST" / "Z2_FIRST").
module dsp19x2_result_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter     LANE_ORDER = "Z1_FIRST"
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [37:0]                 Z_PACKED,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [18:0]                 OUT_DATA,
  output logic                        OUT_LANE,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  input  logic                        FLUSH,
  output logic [$clog2(FIFO_DEPTH):0] COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam bit Z2_FIRST = (LANE_ORDER == "Z2_FIRST");
  localparam logic FIRST_LANE_ID = Z2_FIRST ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } state_t;

  state_t        state;
  logic [37:0]   hold;
  logic [37:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ready_q;
  logic [18:0]   out_data_q;
  logic          out_lane_q;
  logic          out_valid_q;
  logic          push;
  logic          pop;
  logic [37:0]   head;

  // Lane extraction: Z1 lives in the upper 19 bits, Z2 in the lower 19 bits.
  function automatic logic [18:0] first_lane(input logic [37:0] w);
    return Z2_FIRST ? w[18:0] : w[37:19];
  endfunction

  function automatic logic [18:0] second_lane(input logic [37:0] w);
    return Z2_FIRST ? w[37:19] : w[18:0];
  endfunction

  assign head = mem[rd_ptr];

  // Push/pop decisions; flush suppresses both so a flushed edge changes nothing but the clear.
  always_comb begin
    push = IN_VALID && ready_q && !FLUSH;
    pop  = 1'b0;
    if (!FLUSH && (count != '0)) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == SECOND) && OUT_READY) begin
        pop = 1'b1;
      end
    end
  end

  // Next word count; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    if (FLUSH) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // FIFO storage is written at the tail; contents need no reset since count gates reads.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= Z_PACKED;
    end
  end

  // Pointer, count and registered ready bookkeeping; ready stays low while in reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      count   <= count_next;
      ready_q <= (count_next < DEPTH_C);
    end
  end

  // Serializer FSM with registered lane outputs; popping in SECOND avoids a bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      hold        <= '0;
      out_data_q  <= '0;
      out_lane_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (FLUSH) begin
      state       <= IDLE;
      hold        <= '0;
      out_data_q  <= '0;
      out_lane_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold        <= head;
            state       <= FIRST;
            out_valid_q <= 1'b1;
            out_data_q  <= first_lane(head);
            out_lane_q  <= FIRST_LANE_ID;
          end
        end
        FIRST: begin
          if (OUT_READY) begin
            state      <= SECOND;
            out_data_q <= second_lane(hold);
            out_lane_q <= ~FIRST_LANE_ID;
          end
        end
        SECOND: begin
          if (OUT_READY) begin
            if (pop) begin
              hold        <= head;
              state       <= FIRST;
              out_valid_q <= 1'b1;
              out_data_q  <= first_lane(head);
              out_lane_q  <= FIRST_LANE_ID;
            end else begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = ready_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LANE  = out_lane_q;
  assign OUT_VALID = out_valid_q;
  assign COUNT     = count;

endmodule
